// File: rtl/serial_divider_pkg.sv
// Shared definitions for the RV32M serial divider: width, FSM states, op codes.
package serial_divider_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   function automatic logic [XLEN-1:0] absIf(input logic [XLEN-1:0] v, input logic en);
      return (en && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Request/response bundle between the execute stage and the serial divider.
interface serial_divider_if import serial_divider_pkg::*; ();

   logic            i_start;
   logic [1:0]      i_op;
   logic [XLEN-1:0] i_dividend;
   logic [XLEN-1:0] i_divisor;
   logic            o_busy;
   logic            o_done;
   logic [XLEN-1:0] o_result;

   modport master (
      output i_start, i_op, i_dividend, i_divisor,
      input  o_busy, o_done, o_result
   );

   modport slave (
      input  i_start, i_op, i_dividend, i_divisor,
      output o_busy, o_done, o_result
   );

endinterface

// File: rtl/serial_divider_fullsub.sv
// One-bit full subtractor cell; chained to form the ripple-borrow subtract.
module FULLSUB (
   input  logic a,
   input  logic b,
   input  logic bI,
   output logic d,
   output logic bO
);

   assign d  = a ^ b ^ bI;
   assign bO = (~a & b) | (~(a ^ b) & bI);

endmodule

// File: rtl/serial_divider.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
module serial_divider import serial_divider_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   serial_divider_if.slave  bus
);

   logic [1:0]      r_state;
   logic [4:0]      r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_div;
   logic [XLEN-1:0] r_result;
   logic            r_selRem;
   logic            r_negQ;
   logic            r_negR;

   logic [XLEN:0]   w_shifted;
   logic [XLEN:0]   w_subB;
   logic [XLEN:0]   w_diff;
   logic [XLEN+1:0] w_borrow;
   logic            w_restore;
   logic            w_unusedDiffMsb;
   logic [XLEN-1:0] w_nextRem;
   logic [XLEN-1:0] w_nextQuo;
   logic [XLEN-1:0] w_finalRem;
   logic [XLEN-1:0] w_finalQuo;
   logic            w_signed;
   logic            w_divZero;
   logic            w_overflow;

   assign w_shifted   = {r_rem, r_quo[XLEN-1]};
   assign w_subB      = {1'b0, r_div};
   assign w_borrow[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi <= XLEN; gi++) begin : g_sub
         FULLSUB u_cell (
            .a  (w_shifted[gi]),
            .b  (w_subB[gi]),
            .bI (w_borrow[gi]),
            .d  (w_diff[gi]),
            .bO (w_borrow[gi+1])
         );
      end
   endgenerate

   // A successful subtract always leaves the difference below the divisor, so its MSB is zero.
   assign w_restore       = w_borrow[XLEN+1];
   assign w_unusedDiffMsb = w_diff[XLEN];
   assign w_nextRem       = w_restore ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
   assign w_nextQuo       = {r_quo[XLEN-2:0], ~w_restore};
   assign w_finalRem      = r_negR ? -w_nextRem : w_nextRem;
   assign w_finalQuo      = r_negQ ? -w_nextQuo : w_nextQuo;

   assign w_signed   = ~bus.i_op[0];
   assign w_divZero  = (bus.i_divisor == '0);
   assign w_overflow = w_signed && (bus.i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                                && (bus.i_divisor == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_result <= '0;
         r_selRem <= 1'b0;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.i_start) begin
                  r_selRem <= bus.i_op[1];
                  if (w_divZero) begin
                     r_result <= bus.i_op[1] ? bus.i_dividend : '1;
                     r_state  <= S_DONE;
                  end else if (w_overflow) begin
                     r_result <= bus.i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                     r_state  <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                     r_cnt   <= 5'd31;
                     r_rem   <= '0;
                     r_quo   <= absIf(bus.i_dividend, w_signed);
                     r_div   <= absIf(bus.i_divisor, w_signed);
                     r_negQ  <= w_signed & (bus.i_dividend[XLEN-1] ^ bus.i_divisor[XLEN-1]);
                     r_negR  <= w_signed & bus.i_dividend[XLEN-1];
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               r_rem <= w_nextRem;
               r_quo <= w_nextQuo;
               r_cnt <= r_cnt - 5'd1;
               if (r_cnt == 5'd0) begin
                  r_state  <= S_DONE;
                  r_result <= r_selRem ? w_finalRem : w_finalQuo;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy   = (r_state == S_CALC);
   assign bus.o_done   = (r_state == S_DONE);
   assign bus.o_result = r_result;

endmodule

// File: tb/tb_serial_divider.sv
// Directed and randomized checks of serial_divider against a behavioural RV32M model.
module tb_serial_divider;
   import serial_divider_pkg::*;

   typedef struct {
      logic [XLEN-1:0] result;
      int              latency;
   } expEntry_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   expEntry_t sb[$];

   serial_divider_if bus ();

   serial_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] simulation hung");
   end

   function automatic logic [XLEN-1:0] modelResult(input logic [1:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'h0 : 32'h8000_0000;
      case (op)
         OP_DIV:  return $signed(a) / $signed(b);
         OP_DIVU: return a / b;
         OP_REM:  return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives a one-cycle start; returns #1 into cycle 1.
   task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input bit track);
      expEntry_t e;
      @(negedge clk);
      bus.i_start    = 1'b1;
      bus.i_op       = op;
      bus.i_dividend = a;
      bus.i_divisor  = b;
      if (track) begin
         e.result  = modelResult(op, a, b);
         e.latency = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   // Waits (bounded) for done starting at cycle startCyc, then scores against the queue head.
   task automatic checkOutput(input string tag, input int startCyc);
      expEntry_t e;
      int cyc = startCyc;
      int busyCycles = 0;
      e = sb.pop_front();
      while (!bus.o_done && cyc < 120) begin
         if (bus.o_busy) busyCycles++;
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_seen"},    32'(bus.o_done), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(e.latency));
      check({tag, "_result"},  bus.o_result, e.result);
      check({tag, "_busy"},    32'(busyCycles), 32'(e.latency - startCyc));
      check({tag, "_busyDone"}, 32'(bus.o_busy), 32'd0);
   endtask

   initial begin
      int extraDone;
      logic [1:0] rOp;
      logic [XLEN-1:0] rA;
      logic [XLEN-1:0] rB;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_op = 2'b00;
      bus.i_dividend = '0;
      bus.i_divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy",   32'(bus.o_busy), 32'd0);
      check("reset_done",   32'(bus.o_done), 32'd0);
      check("reset_result", bus.o_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] basic unsigned, back-to-back");
      applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1);
      checkOutput("divu_100_7", 1);
      applyStimulus(OP_REMU, 32'd100, 32'd7, 1'b1);
      checkOutput("remu_100_7", 1);
      @(posedge clk);
      #1;
      check("done_pulse",  32'(bus.o_done), 32'd0);
      check("result_hold", bus.o_result, 32'd2);

      $display("[TB] signed");
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      checkOutput("div_m7_2", 1);
      applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
      checkOutput("rem_m7_2", 1);

      $display("[TB] fast paths");
      applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b1);
      checkOutput("divu_5_0", 1);
      applyStimulus(OP_REMU, 32'd5, 32'd0, 1'b1);
      checkOutput("remu_5_0", 1);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      checkOutput("div_ovf", 1);
      applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      checkOutput("rem_ovf", 1);

      $display("[TB] random operands");
      for (int i = 0; i < 6; i++) begin
         rOp = 2'($urandom_range(0, 3));
         rA  = $urandom;
         rB  = 32'($urandom_range(1, 5000));
         if (i[0]) rB = -rB;
         applyStimulus(rOp, rA, rB, 1'b1);
         checkOutput("random", 1);
      end

      $display("[TB] start during CALC is ignored");
      applyStimulus(OP_DIVU, 32'd1000, 32'd10, 1'b1);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      bus.i_start    = 1'b1;
      bus.i_op       = OP_DIVU;
      bus.i_dividend = 32'd9;
      bus.i_divisor  = 32'd3;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      checkOutput("ignore_start", 11);
      extraDone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.o_done) extraDone++;
      end
      check("no_second_done", 32'(extraDone), 32'd0);

      $display("[TB] reset mid-operation");
      applyStimulus(OP_DIVU, 32'd500, 32'd3, 1'b1);
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      void'(sb.pop_back());
      check("rst_busy",   32'(bus.o_busy), 32'd0);
      check("rst_done",   32'(bus.o_done), 32'd0);
      check("rst_result", bus.o_result, 32'd0);
      rst = 1'b0;
      applyStimulus(OP_DIVU, 32'd9, 32'd3, 1'b1);
      checkOutput("after_rst", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_divider.md
# serial_divider

Multi-cycle RV32M divide unit executing DIV, DIVU, REM and REMU with a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the ALU in the execute stage. The pipeline issues a start pulse, stalls on `busy`, and captures `result` on the one-cycle `done` pulse. The per-bit subtract is a ripple-borrow chain of full-subtractor cells, the borrow-side counterpart of the adder's full-adder cells.

## Interface
- `XLEN`, 32: operand and result width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only when not `busy`.
- `op` input 2: operation, equal to funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `dividend` input XLEN: rs1. Sampled with `start`.
- `divisor` input XLEN: rs2. Sampled with `start`.
- `busy` output 1: high while an operation is in flight. Reset value 0.
- `done` output 1: single-cycle pulse when `result` becomes valid. Reset value 0.
- `result` output XLEN: quotient or remainder. Reset value 0. Held until the next accepted `start`.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Accept: in IDLE or DONE with `start`=1, latch `op`, operands and sign information.
  - Signed ops (op[0]=0): the working dividend and divisor are the absolute values. Record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Unsigned ops: `neg_q` = `neg_r` = 0.
- Fast paths: from accept, go directly to DONE and load `result`.
  - Divisor = 0: quotient = all ones; remainder = original dividend.
  - Signed overflow (DIV/REM, dividend = 0x8000_0000, divisor = 0xFFFF_FFFF): quotient = 0x8000_0000; remainder = 0.
- CALC: 5-bit counter runs 31 down to 0. Each cycle:
  - Shift the partial remainder left, inserting the MSB of the quotient/dividend shift register.
  - Subtract the divisor over XLEN+1 bits through the subtractor chain.
  - Final borrow = 0: the partial remainder takes the difference and the new quotient LSB is 1.
  - Final borrow = 1: the remainder is kept and the quotient LSB is 0.
- Counter reaches 0: go to DONE. `result` = quotient (op[1]=0) or remainder (op[1]=1), two's-complement negated if `neg_q` or `neg_r` respectively.
- DONE with no `start`: go to IDLE next cycle.
- DONE with `start`: accept the new operation, as in IDLE.
- `start` while in CALC: ignored, with no effect on the operation in flight.
- `rst` in any state:
  - Next state IDLE.
  - `busy`, `done`, `result`, counter and datapath registers all cleared.
  - The in-flight operation is discarded.

## Timing
- Start sampled at edge 0.
- Normal path: CALC occupies cycles 1–32. DONE is cycle 33, with `done`=1 and `result` valid during that cycle. Latency is 33 cycles start-to-done.
- Fast path: `done`=1 and `result` valid in cycle 1.
- `busy` rises in cycle 1 (normal path only) and falls in the DONE cycle.
- Back-to-back: a `start` in the DONE cycle yields the next result no earlier than 33 cycles later.
- Sign fix-up and result select are registered at the CALC→DONE edge. There is no combinational path from the inputs to `result`.
- `result` changes only on entry to DONE or on `rst`.

## Structure
- Shared package: the state enum (IDLE, CALC, DONE), the `op` encodings as named constants, and `XLEN`.
- Sub-module `FULLSUB`: inputs a, b, bI; outputs d, bO.
  - d = a ^ b ^ bI.
  - bO = (~a & b) | (~(a ^ b) & bI).
- The divider instantiates XLEN+1 `FULLSUB` cells in a ripple-borrow chain via generate. The final bO is the restore decision.

## Test plan
- DIVU 100 / 7: `done` in cycle 33 with `result`=14. Then REMU with the same operands: `result`=2; `busy` high for cycles 1–32.
- DIV 0xFFFF_FFF9 (-7) / 2: `result`=0xFFFF_FFFD (-3). REM with the same operands: `result`=0xFFFF_FFFF (-1).
- DIVU 5 / 0: `done` in cycle 1 with `result`=0xFFFF_FFFF. REMU 5 / 0: `result`=5.
- DIV 0x8000_0000 / 0xFFFF_FFFF: `result`=0x8000_0000 in cycle 1. REM with the same operands: `result`=0.
- `start` (DIVU 9/3) pulsed in cycle 10 of a running DIVU 1000/10: ignored. `result`=100 at cycle 33 and no second `done`.
- `rst` asserted in cycle 15 of CALC:
  - Next cycle: `busy`=0, `done`=0, `result`=0.
  - A new DIVU 9 / 3 started afterwards returns 3 after 33 cycles.
